// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback port arbiter.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  // Entry payload is sized for the widest supported datapath; narrower configs use the low bits.
  localparam int WB_DATA_W  = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]  data;
    logic                  live;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer of MDU results with per-entry live bits and rd-match kill.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  input  logic                        pop,
  input  logic                        kill_en,
  input  logic [REG_ADDR_W-1:0]       kill_rd,
  output wb_entry_t                   head,
  output wb_entry_t [DEPTH-1:0]       entries,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;

  assign head    = mem[rd_ptr];
  assign entries = mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Popped slots drop their live bit so the pending mask can be built from live bits alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_ptr == PTR_W'(i))
          mem[i] <= push_entry;
        else if (pop && rd_ptr == PTR_W'(i))
          mem[i].live <= 1'b0;
        else if (kill_en && mem[i].rd == kill_rd)
          mem[i].live <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority, MDU results bypass or queue.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [WIDTH-1:0]      ResultW,
  input  logic                  MduValid,
  output logic                  MduReady,
  input  logic [REG_ADDR_W-1:0] MduRd,
  input  logic [WIDTH-1:0]      MduResult,
  output logic                  RfWE,
  output logic [REG_ADDR_W-1:0] RfRd,
  output logic [WIDTH-1:0]      RfWD,
  output logic                  StallReq,
  output logic [NUM_REGS-1:0]   PendingRdMask
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int STV_W = $clog2(STARVE_LIMIT+1);

  wb_entry_t             head, push_entry;
  wb_entry_t [DEPTH-1:0] entries;
  logic [CNT_W-1:0]      count;
  logic [STV_W-1:0]      starve_cnt;
  logic                  stall_q;
  logic pipe_wr, xfer, empty, head_live, bypass, push, pop;

  assign pipe_wr   = RegWriteW && (RdW != '0);
  assign MduReady  = !rst && (count < CNT_W'(DEPTH));
  assign xfer      = MduValid && MduReady;
  assign empty     = (count == '0);
  assign head_live = !empty && head.live;
  assign bypass    = !pipe_wr && empty && xfer && (MduRd != '0);
  // An MDU result is older than writeback, so a same-rd pipeline write makes it obsolete.
  assign push      = xfer && (MduRd != '0) && !bypass && !(pipe_wr && MduRd == RdW);
  // Dead heads leave regardless of who owns the port.
  assign pop       = !rst && !empty && (!head.live || !pipe_wr);

  assign push_entry = '{rd: MduRd, data: WB_DATA_W'(MduResult), live: 1'b1};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (pipe_wr),
    .kill_rd    (RdW),
    .head       (head),
    .entries    (entries),
    .count      (count)
  );

  always_comb begin
    RfWE = 1'b0;
    RfRd = '0;
    RfWD = '0;
    if (!rst) begin
      if (pipe_wr) begin
        RfWE = 1'b1;
        RfRd = RdW;
        RfWD = ResultW;
      end else if (head_live) begin
        RfWE = 1'b1;
        RfRd = head.rd;
        RfWD = head.data[WIDTH-1:0];
      end else if (bypass) begin
        RfWE = 1'b1;
        RfRd = MduRd;
        RfWD = MduResult;
      end
    end
  end

  always_comb begin
    PendingRdMask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (entries[i].live) PendingRdMask = PendingRdMask | rd_onehot(entries[i].rd);
    if (rst) PendingRdMask = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (empty || pop)
        starve_cnt <= '0;
      else if (head_live && starve_cnt != STV_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
      stall_q <= (starve_cnt == STV_W'(STARVE_LIMIT)) && !pop;
    end
  end

  assign StallReq = stall_q && !rst;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: bypass, buffering, WAW kill, starvation, reset, x0.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        MduValid;
  logic        MduReady;
  logic [4:0]  MduRd;
  logic [31:0] MduResult;
  logic        RfWE;
  logic [4:0]  RfRd;
  logic [31:0] RfWD;
  logic        StallReq;
  logic [31:0] PendingRdMask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.WIDTH(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .RegWriteW     (RegWriteW),
    .RdW           (RdW),
    .ResultW       (ResultW),
    .MduValid      (MduValid),
    .MduReady      (MduReady),
    .MduRd         (MduRd),
    .MduResult     (MduResult),
    .RfWE          (RfWE),
    .RfRd          (RfRd),
    .RfWD          (RfWD),
    .StallReq      (StallReq),
    .PendingRdMask (PendingRdMask)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
    RegWriteW = we; RdW = rd; ResultW = d;
  endtask

  task automatic mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    MduValid = v; MduRd = rd; MduResult = d;
  endtask

  initial begin
    rst = 1'b1;
    pipe(1'b0, 5'd0, 32'h0);
    mdu(1'b0, 5'd0, 32'h0);
    step(); step();
    settle();
    chk("rst_we",    {31'b0, RfWE},     32'd0);
    chk("rst_ready", {31'b0, MduReady}, 32'd0);
    chk("rst_stall", {31'b0, StallReq}, 32'd0);
    chk("rst_mask",  PendingRdMask,     32'd0);
    step();
    rst = 1'b0;

    // idle-port bypass
    mdu(1'b1, 5'd5, 32'hAA);
    settle();
    chk("byp_we",   {31'b0, RfWE}, 32'd1);
    chk("byp_rd",   {27'b0, RfRd}, 32'd5);
    chk("byp_wd",   RfWD,          32'hAA);
    chk("byp_mask", PendingRdMask, 32'd0);
    step();
    mdu(1'b0, 5'd0, 32'h0);
    settle();
    chk("byp_after_we",   {31'b0, RfWE}, 32'd0);
    chk("byp_after_mask", PendingRdMask, 32'd0);
    step();

    // buffering while the pipeline owns the port, then drain
    pipe(1'b1, 5'd3, 32'h33);
    mdu(1'b1, 5'd7, 32'h77);
    settle();
    chk("buf_a_rd",    {27'b0, RfRd},     32'd3);
    chk("buf_a_wd",    RfWD,              32'h33);
    chk("buf_a_ready", {31'b0, MduReady}, 32'd1);
    step();
    mdu(1'b1, 5'd8, 32'h88);
    settle();
    chk("buf_b_ready", {31'b0, MduReady}, 32'd1);
    chk("buf_b_mask",  PendingRdMask,     32'h80);
    step();
    mdu(1'b0, 5'd0, 32'h0);
    settle();
    chk("buf_c_ready", {31'b0, MduReady}, 32'd0);
    chk("buf_c_mask",  PendingRdMask,     32'h180);
    chk("buf_c_rd",    {27'b0, RfRd},     32'd3);
    step();
    pipe(1'b0, 5'd0, 32'h0);
    settle();
    chk("drain7_we", {31'b0, RfWE}, 32'd1);
    chk("drain7_rd", {27'b0, RfRd}, 32'd7);
    chk("drain7_wd", RfWD,          32'h77);
    step();
    settle();
    chk("drain8_rd",    {27'b0, RfRd},     32'd8);
    chk("drain8_wd",    RfWD,              32'h88);
    chk("drain8_mask",  PendingRdMask,     32'h100);
    chk("drain8_ready", {31'b0, MduReady}, 32'd1);
    step();
    settle();
    chk("drain_done_we",   {31'b0, RfWE}, 32'd0);
    chk("drain_done_mask", PendingRdMask, 32'd0);
    step();

    // WAW kill of a buffered entry
    pipe(1'b1, 5'd3, 32'h33);
    mdu(1'b1, 5'd9, 32'h99);
    step();
    mdu(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd9, 32'h999);
    settle();
    chk("kill_mask_before", PendingRdMask, 32'h200);
    chk("kill_pipe_wd",     RfWD,          32'h999);
    step();
    pipe(1'b0, 5'd0, 32'h0);
    settle();
    chk("kill_mask_after", PendingRdMask, 32'd0);
    chk("kill_dead_we",    {31'b0, RfWE}, 32'd0);
    step();
    settle();
    chk("kill_popped_we", {31'b0, RfWE}, 32'd0);
    step();

    // same-cycle kill of an incoming transfer
    pipe(1'b1, 5'd12, 32'h1212);
    mdu(1'b1, 5'd12, 32'hBAD);
    settle();
    chk("drop_wd", RfWD, 32'h1212);
    step();
    pipe(1'b0, 5'd0, 32'h0);
    mdu(1'b0, 5'd0, 32'h0);
    settle();
    chk("drop_we",   {31'b0, RfWE}, 32'd0);
    chk("drop_mask", PendingRdMask, 32'd0);
    step();

    // starvation
    pipe(1'b1, 5'd3, 32'h33);
    mdu(1'b1, 5'd10, 32'hA0);
    step();
    mdu(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("starve_wait%0d", i), {31'b0, StallReq}, 32'd0);
      step();
    end
    settle();
    chk("starve_rise", {31'b0, StallReq}, 32'd1);
    step();
    settle();
    chk("starve_hold", {31'b0, StallReq}, 32'd1);
    step();
    pipe(1'b0, 5'd0, 32'h0);
    settle();
    chk("starve_wr_rd",  {27'b0, RfRd},     32'd10);
    chk("starve_wr_wd",  RfWD,              32'hA0);
    chk("starve_wr_stl", {31'b0, StallReq}, 32'd1);
    step();
    settle();
    chk("starve_fall", {31'b0, StallReq}, 32'd0);
    chk("starve_we",   {31'b0, RfWE},     32'd0);
    step();

    // reset with a full FIFO and StallReq high
    pipe(1'b1, 5'd3, 32'h33);
    mdu(1'b1, 5'd11, 32'hB0);
    step();
    mdu(1'b1, 5'd12, 32'hC0);
    step();
    mdu(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) step();
    settle();
    chk("pre_rst_stall", {31'b0, StallReq}, 32'd1);
    chk("pre_rst_ready", {31'b0, MduReady}, 32'd0);
    chk("pre_rst_mask",  PendingRdMask,     32'h1800);
    step();
    rst = 1'b1;
    settle();
    chk("mid_rst_we",    {31'b0, RfWE},     32'd0);
    chk("mid_rst_stall", {31'b0, StallReq}, 32'd0);
    chk("mid_rst_mask",  PendingRdMask,     32'd0);
    chk("mid_rst_ready", {31'b0, MduReady}, 32'd0);
    step();
    rst = 1'b0;
    pipe(1'b0, 5'd0, 32'h0);
    settle();
    chk("post_rst_ready", {31'b0, MduReady}, 32'd1);
    chk("post_rst_mask",  PendingRdMask,     32'd0);
    chk("post_rst_we",    {31'b0, RfWE},     32'd0);
    chk("post_rst_stall", {31'b0, StallReq}, 32'd0);
    step();
    settle();
    chk("post_rst_we2", {31'b0, RfWE}, 32'd0);
    step();

    // x0 handling
    mdu(1'b1, 5'd0, 32'hDEAD);
    settle();
    chk("x0_mdu_we",    {31'b0, RfWE},     32'd0);
    chk("x0_mdu_ready", {31'b0, MduReady}, 32'd1);
    step();
    mdu(1'b0, 5'd0, 32'h0);
    settle();
    chk("x0_mdu_mask", PendingRdMask, 32'd0);
    chk("x0_mdu_we2",  {31'b0, RfWE}, 32'd0);
    step();
    pipe(1'b1, 5'd3, 32'h33);
    mdu(1'b1, 5'd13, 32'hD0);
    step();
    mdu(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd0, 32'h55);
    settle();
    chk("x0_pipe_we", {31'b0, RfWE}, 32'd1);
    chk("x0_pipe_rd", {27'b0, RfRd}, 32'd13);
    chk("x0_pipe_wd", RfWD,          32'hD0);
    step();
    pipe(1'b0, 5'd0, 32'h0);
    settle();
    chk("x0_pipe_mask", PendingRdMask, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback stage and the long-latency multiply/divide unit (MDU).
- Pipeline writes always win. MDU results wait in a small FIFO and drain on cycles when the pipeline is not writing.
- A starvation counter requests a pipeline bubble when an MDU result waits too long.
- Sits between the writeback stage, the MDU and the register file, and exports a pending-rd mask to the hazard unit.

Parameters:
- WIDTH, 32, data width of results and register-file write data.
- DEPTH, 2, MDU result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 4, cycles a live FIFO head may wait before StallReq asserts (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWriteW  in  1  pipeline writeback enable.
- RdW  in  5  pipeline destination register.
- ResultW  in  WIDTH  pipeline writeback data.
- MduValid  in  1  MDU result valid.
- MduReady  out  1  arbiter can accept MDU result.
- MduRd  in  5  MDU destination register.
- MduResult  in  WIDTH  MDU result data.
- RfWE  out  1  register-file write enable.
- RfRd  out  5  register-file write address.
- RfWD  out  WIDTH  register-file write data.
- StallReq  out  1  request to hazard unit to inject one writeback bubble.
- PendingRdMask  out  32  bit r set if a live FIFO entry targets xr.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst=1:
  - RfWE=0, MduReady=0, StallReq=0, PendingRdMask=0.
  - FIFO pointers, count, live bits and the starvation counter clear at the edge.
  - Reset mid-operation discards buffered results; the MDU is reset in the same cycle.
- Handshake: an MDU transfer occurs when MduValid && MduReady.
  - MduReady = (count < DEPTH). It is independent of the same-cycle pop, so push-when-full is never allowed.
  - MduValid may hold its data until accepted.
- Port grant is combinational and evaluated each cycle in this priority order:
  1. RegWriteW && RdW!=0: write the pipeline. RfWE=1, RfRd=RdW, RfWD=ResultW.
  2. Otherwise, if the FIFO head is live: write the head and pop it.
  3. Otherwise, if the FIFO is empty and an MDU transfer occurs with MduRd!=0: bypass. Write MduRd/MduResult directly; nothing is enqueued.
  4. Otherwise RfWE=0. RfRd and RfWD are don't-care; drive 0.
- Writes to x0 are never issued. RegWriteW with RdW=0 counts as no pipeline write.
- An MDU transfer with MduRd=0 is accepted and discarded.
- Enqueue: an MDU transfer that is not bypassed and has MduRd!=0 pushes {rd, data, live=1} at the tail.
- Kill (WAW ordering): an MDU result is always older than the instruction in writeback.
  - When the pipeline writes rd X, every FIFO entry with rd==X has live cleared at that edge.
  - An MDU result transferring that same cycle with MduRd==X is dropped, not enqueued.
- Dead head: a non-live head is popped without a write. This pop happens even on cycles the pipeline owns the port.
- Push and pop may occur in the same cycle. count += push - pop. Pointers wrap modulo DEPTH.
- PendingRdMask is the OR of one-hot(rd) over live entries. It is combinational from registered state and excludes bypassed results.
- Starvation counter:
  - Increments when the head is live and not popped. Clears on a pop or when the FIFO is empty. Saturates at STARVE_LIMIT.
  - StallReq is registered: it is 1 in the cycle after the counter reaches STARVE_LIMIT, and holds until the cycle after the head pops.
  - The hazard unit guarantees a RegWriteW=0 cycle within 2 cycles of StallReq.
- Latency:
  - Pipeline write: 0 cycles (same-cycle port drive).
  - MDU result, idle port: 0 cycles (bypass).
  - MDU result, buffered: written on the first cycle without a pipeline write in which it is the live head.

Decomposition:
- Shared package wb_pkg:
  - typedef wb_entry_t {logic [4:0] rd; logic [WIDTH-1:0] data; logic live;}
  - constants REG_ADDR_W=5 and NUM_REGS=32.
- One natural sub-module: wb_result_fifo.
  - Holds the DEPTH-entry circular buffer with push/pop, count, per-entry live bits and rd-match kill.
  - Exposes head and entries to the top level for mask generation.
- The arbiter top contains the grant logic and the starvation counter.

Test Plan:
- Idle port bypass: RegWriteW=0, MduValid=1, MduRd=5, MduResult=0xAA -> same cycle RfWE=1, RfRd=5, RfWD=0xAA; PendingRdMask stays 0.
- Buffering and drain:
  - Stimulus: RegWriteW=1 (RdW=3) for 3 cycles while the MDU sends rd=7 then rd=8.
  - Response: MduReady drops after 2 accepts; PendingRdMask=0x180.
  - Response: once RegWriteW=0, rd7 then rd8 are written on consecutive cycles; the mask clears.
- WAW kill: FIFO holds rd=9 live, then the pipeline writes RdW=9 -> the entry goes dead and the mask bit clears. The next idle cycle pops it with RfWE=0; rd9 is never overwritten by the MDU value.
- Starvation:
  - Stimulus: STARVE_LIMIT=4, FIFO head live, RegWriteW=1 continuously.
  - Response: StallReq rises after 4 waiting cycles. When RegWriteW drops for one cycle, the head is written and StallReq falls next cycle.
- Reset mid-operation: FIFO full, StallReq=1, assert rst one cycle -> all outputs 0 during reset; after release MduReady=1, mask=0, and no stale write ever appears.
- x0 handling: MduRd=0 accepted and discarded (no write, no enqueue); RegWriteW=1 with RdW=0 lets the live FIFO head drain that cycle.
